// File: rtl/pwm_cap_pkg.sv
// Shared state encoding and default widths for the PWM capture block.
package pwm_cap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } pwm_cap_state_e;

    localparam int CNT_WIDTH_DEF  = 32;
    localparam int PSCR_WIDTH_DEF = 20;
    localparam int SYNC_STAGE_DEF = 2;

endpackage

// File: rtl/pwm_cap_sync_edge.sv
// Synchronises async pwm_i and emits 1-cycle rise/fall pulses, SYNC_STAGE+1 cycles after the input edge.
// No backpressure: edges are reported unconditionally.
module pwm_cap_sync_edge #(
    parameter int SYNC_STAGE = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwm_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGE-1:0] sync_q;
    logic                  hist_q;
    logic                  level;

    assign level = sync_q[SYNC_STAGE-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGE-2:0], pwm_i};
            hist_q <= level;
        end
    end

    // Both pulses come from the same flop pair so rise and fall share one latency.
    assign rise_o = level & ~hist_q;
    assign fall_o = ~level & hist_q;

endmodule

// File: rtl/pwm_cap_core.sv
// Measures period/high time of async pwm_i in prescaled ticks; result 1 cycle after the edge is seen.
// One-entry valid/ready buffer: a new result arriving while it is full is dropped and flagged as overrun.
module pwm_cap_core
    import pwm_cap_pkg::*;
#(
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int PSCR_WIDTH = PSCR_WIDTH_DEF,
    parameter int SYNC_STAGE = SYNC_STAGE_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    input  logic                  pwm_i,
    output logic                  meas_valid_o,
    input  logic                  meas_ready_i,
    output logic [CNT_WIDTH-1:0]  period_o,
    output logic [CNT_WIDTH-1:0]  high_o,
    output logic                  ovf_o,
    output logic                  overrun_o,
    output logic                  irq_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic rise;
    logic fall;

    pwm_cap_sync_edge #(
        .SYNC_STAGE (SYNC_STAGE)
    ) u_sync_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pwm_i  (pwm_i),
        .rise_o (rise),
        .fall_o (fall)
    );

    pwm_cap_state_e        state_q, state_d;
    logic [PSCR_WIDTH-1:0] pscr_q;
    logic [PSCR_WIDTH-1:0] div_q;
    logic [CNT_WIDTH-1:0]  period_cnt_q;
    logic [CNT_WIDTH-1:0]  high_cnt_q;
    logic [CNT_WIDTH-1:0]  high_res_q;
    logic                  tick;

    logic publish;
    logic ovf_set;
    logic cnt_clr;
    logic period_inc;
    logic high_inc;
    logic high_cap;
    logic arm_entry;

    assign tick = (div_q == pscr_q);

    always_comb begin
        state_d    = state_q;
        publish    = 1'b0;
        ovf_set    = 1'b0;
        cnt_clr    = 1'b0;
        period_inc = 1'b0;
        high_inc   = 1'b0;
        high_cap   = 1'b0;
        arm_entry  = 1'b0;

        if (clr_i) begin
            state_d   = en_i ? ARM : IDLE;
            arm_entry = en_i;
            cnt_clr   = 1'b1;
        end else if (!en_i) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ARM;
                    arm_entry = 1'b1;
                    cnt_clr   = 1'b1;
                end
                ARM: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_clr = 1'b1;
                    end
                end
                HIGH: begin
                    // high_cnt never exceeds period_cnt, so checking period alone covers both.
                    if (tick && period_cnt_q == CNT_MAX) begin
                        ovf_set   = 1'b1;
                        state_d   = ARM;
                        arm_entry = 1'b1;
                        cnt_clr   = 1'b1;
                    end else if (fall) begin
                        state_d    = LOW;
                        high_cap   = 1'b1;
                        period_inc = tick;
                    end else begin
                        period_inc = tick;
                        high_inc   = tick;
                    end
                end
                LOW: begin
                    if (tick && period_cnt_q == CNT_MAX) begin
                        ovf_set   = 1'b1;
                        state_d   = ARM;
                        arm_entry = 1'b1;
                        cnt_clr   = 1'b1;
                    end else if (rise) begin
                        publish = 1'b1;
                        state_d = HIGH;
                        cnt_clr = 1'b1;
                    end else begin
                        period_inc = tick;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Prescale value only changes at a period boundary so one measurement never mixes scales.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pscr_q <= '0;
            div_q  <= '0;
        end else begin
            if (arm_entry || rise) begin
                pscr_q <= pscr_i;
            end
            if (cnt_clr || rise || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + PSCR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            high_res_q   <= '0;
        end else begin
            if (cnt_clr) begin
                period_cnt_q <= '0;
                high_cnt_q   <= '0;
            end else begin
                if (period_inc) begin
                    period_cnt_q <= period_cnt_q + CNT_WIDTH'(1);
                end
                if (high_inc) begin
                    high_cnt_q <= high_cnt_q + CNT_WIDTH'(1);
                end
            end
            if (high_cap) begin
                high_res_q <= high_cnt_q + CNT_WIDTH'(tick);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            meas_valid_o <= 1'b0;
            period_o     <= '0;
            high_o       <= '0;
            ovf_o        <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_o <= 1'b1;
            end
            if (publish) begin
                if (!meas_valid_o || meas_ready_i) begin
                    period_o     <= period_cnt_q + CNT_WIDTH'(tick);
                    high_o       <= high_res_q;
                    meas_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (meas_valid_o && meas_ready_i) begin
                meas_valid_o <= 1'b0;
            end
        end
    end

    assign irq_o = meas_valid_o | ovf_o | overrun_o;

endmodule

// File: tb/tb_pwm_cap_core.sv
// Directed bench for pwm_cap_core with 8-bit counters so saturation is reachable quickly.
module tb_pwm_cap_core;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic [19:0] pscr;
    logic        pwm;
    logic        meas_valid;
    logic        meas_ready;
    logic [7:0]  period;
    logic [7:0]  high;
    logic        ovf;
    logic        overrun;
    logic        irq;

    int n_cmp  = 0;
    int n_err  = 0;
    int hs_cnt = 0;
    int hs0;

    pwm_cap_core #(
        .CNT_WIDTH  (8),
        .PSCR_WIDTH (20),
        .SYNC_STAGE (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .clr_i        (clr),
        .pscr_i       (pscr),
        .pwm_i        (pwm),
        .meas_valid_o (meas_valid),
        .meas_ready_i (meas_ready),
        .period_o     (period),
        .high_o       (high),
        .ovf_o        (ovf),
        .overrun_o    (overrun),
        .irq_o        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes observed mid-cycle, one per cycle in which valid&ready holds.
    always @(negedge clk) begin
        if (!rst && meas_valid && meas_ready) hs_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic restart();
        pwm = 1'b0;
        en  = 1'b0;
        step(6);
        en  = 1'b1;
        step(2);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; pscr = '0; pwm = 1'b0; meas_ready = 1'b0;
        step(3);
        chk("rst_valid",   32'(meas_valid), 32'd0);
        chk("rst_period",  32'(period),     32'd0);
        chk("rst_high",    32'(high),       32'd0);
        chk("rst_ovf",     32'(ovf),        32'd0);
        chk("rst_overrun", 32'(overrun),    32'd0);
        chk("rst_irq",     32'(irq),        32'd0);

        // 10-cycle period, 3 high, prescale 0
        rst = 1'b0; en = 1'b1; meas_ready = 1'b1;
        step(2);
        for (int i = 0; i < 3; i++) begin
            pwm = 1'b1; step(3);
            pwm = 1'b0; step(7);
        end
        pwm = 1'b1; step(6);
        chk("t1_period", 32'(period),     32'd10);
        chk("t1_high",   32'(high),       32'd3);
        chk("t1_hs",     32'(hs_cnt),     32'd3);
        chk("t1_valid",  32'(meas_valid), 32'd0);
        chk("t1_irq",    32'(irq),        32'd0);

        // prescale 3, then prescale 0 requested mid-period
        pscr = 20'd3;
        restart();
        pwm = 1'b1; step(20); pwm = 1'b0; step(60);
        pwm = 1'b1; step(10);
        chk("t2_p1_period", 32'(period), 32'd20);
        chk("t2_p1_high",   32'(high),   32'd5);
        step(10); pwm = 1'b0; step(30);
        pscr = 20'd0;
        step(30);
        pwm = 1'b1; step(10);
        chk("t2_p2_period", 32'(period), 32'd20);
        chk("t2_p2_high",   32'(high),   32'd5);
        step(10); pwm = 1'b0; step(60);
        pwm = 1'b1; step(10);
        chk("t2_p3_period", 32'(period), 32'd80);
        chk("t2_p3_high",   32'(high),   32'd20);

        // held high: counter saturates on the 256th tick after the rise is seen
        restart();
        pwm = 1'b1;
        step(258);
        chk("t3_ovf_early",   32'(ovf),        32'd0);
        step(1);
        chk("t3_ovf",         32'(ovf),        32'd1);
        chk("t3_irq",         32'(irq),        32'd1);
        chk("t3_no_valid",    32'(meas_valid), 32'd0);
        chk("t3_period_hold", 32'(period),     32'd80);
        clr = 1'b1; step(1); clr = 1'b0;
        chk("t3_clr_ovf",    32'(ovf),    32'd0);
        chk("t3_clr_period", 32'(period), 32'd0);
        chk("t3_clr_irq",    32'(irq),    32'd0);

        // consumer stalled: second result dropped
        pwm = 1'b0; meas_ready = 1'b0;
        step(5);
        pwm = 1'b1; step(4); pwm = 1'b0; step(6);
        pwm = 1'b1; step(2); pwm = 1'b0; step(10);
        pwm = 1'b1; step(6);
        chk("t4_valid",   32'(meas_valid), 32'd1);
        chk("t4_period",  32'(period),     32'd10);
        chk("t4_high",    32'(high),       32'd4);
        chk("t4_overrun", 32'(overrun),    32'd1);
        meas_ready = 1'b1;
        step(1);
        chk("t4_hs_valid",    32'(meas_valid), 32'd0);
        chk("t4_period_hold", 32'(period),     32'd10);

        // enable dropped while high; re-enabled mid-high
        restart();
        hs0 = hs_cnt;
        pwm = 1'b1; step(5);
        en = 1'b0;  step(3);
        en = 1'b1;  step(2);
        pwm = 1'b0; step(5);
        pwm = 1'b1; step(3);
        pwm = 1'b0; step(9);
        chk("t5_no_publish", 32'(hs_cnt), 32'(hs0));
        pwm = 1'b1; step(6);
        chk("t5_publish",     32'(hs_cnt),  32'(hs0 + 1));
        chk("t5_period",      32'(period),  32'd12);
        chk("t5_high",        32'(high),    32'd3);
        chk("t5_overrun_kept", 32'(overrun), 32'd1);

        // reset while in LOW with a result pending
        restart();
        meas_ready = 1'b0;
        pwm = 1'b1; step(3); pwm = 1'b0; step(7);
        pwm = 1'b1; step(6); pwm = 1'b0; step(4);
        chk("t6_valid",  32'(meas_valid), 32'd1);
        chk("t6_period", 32'(period),     32'd10);
        chk("t6_high",   32'(high),       32'd3);
        rst = 1'b1; step(1);
        chk("t6_rst_valid",   32'(meas_valid), 32'd0);
        chk("t6_rst_period",  32'(period),     32'd0);
        chk("t6_rst_high",    32'(high),       32'd0);
        chk("t6_rst_ovf",     32'(ovf),        32'd0);
        chk("t6_rst_overrun", 32'(overrun),    32'd0);
        chk("t6_rst_irq",     32'(irq),        32'd0);
        rst = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
